// File: rtl/synth_pkg.sv
// Shared types and constants for the synth voice path (allocator and oscillator-bank wrapper).
// Also holds the note-to-period conversion used to build the period ROM at elaboration time.
package synth_pkg;

    localparam int NOTE_W      = 7;
    localparam int VEL_W       = 7;
    localparam int PERIOD_W    = 23;
    // Fixed storage width for voice age; the allocator saturates at its own AGE_W (<= 8).
    localparam int AGE_FIELD_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        SCAN,
        COMMIT
    } alloc_state_t;

    typedef struct packed {
        logic                   active;
        logic [NOTE_W-1:0]      note;
        logic [VEL_W-1:0]       vel;
        logic [PERIOD_W-1:0]    period;
        logic [AGE_FIELD_W-1:0] age;
    } voice_t;

    // Equal-tempered pitch, A4 (note 69) = 440 Hz; period rounded to nearest clock cycle.
    function automatic logic [PERIOD_W-1:0] note_to_period(input int clk_hz, input int note);
        real freq;
        freq = 440.0 * (2.0 ** ((real'(note) - 69.0) / 12.0));
        return PERIOD_W'($rtoi(real'(clk_hz) / freq + 0.5));
    endfunction

endpackage

// File: rtl/voice_allocator_rom.sv
// note_period_rom: 128-entry registered lookup, MIDI note -> oscillator period in clk cycles.
// One cycle read latency; contents are constants computed from CLK_HZ at elaboration.
module note_period_rom
    import synth_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic                clk,
    input  logic [NOTE_W-1:0]   note,
    output logic [PERIOD_W-1:0] period
);

    logic [PERIOD_W-1:0] table_w [128];

    for (genvar i = 0; i < 128; i++) begin : g_tab
        localparam logic [PERIOD_W-1:0] P = note_to_period(CLK_HZ, i);
        assign table_w[i] = P;
    end

    always_ff @(posedge clk) begin
        period <= table_w[note];
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphony scheduler: maps note-on/off events onto NUM_VOICES oscillator voices with oldest-voice stealing.
// One event in flight; outputs update NUM_VOICES+2 cycles after the handshake.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int CLK_HZ     = 50_000_000,
    parameter int AGE_W      = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           panic,
    input  logic                           ev_valid,
    output logic                           ev_ready,
    input  logic                           ev_on,
    input  logic [NOTE_W-1:0]              ev_note,
    input  logic [VEL_W-1:0]               ev_vel,
    output logic [NUM_VOICES*PERIOD_W-1:0] voice_period,
    output logic [NUM_VOICES*VEL_W-1:0]    voice_volume,
    output logic [NUM_VOICES-1:0]          voice_restart,
    output logic [NUM_VOICES-1:0]          voice_active
);

    localparam int                     IDX_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [AGE_FIELD_W-1:0] AGE_MAX  = AGE_FIELD_W'((1 << AGE_W) - 1);

    alloc_state_t           state, state_nxt;
    voice_t                 voices [NUM_VOICES];
    voice_t                 cur;

    logic                   ready_q;
    logic [NUM_VOICES-1:0]  restart_q;
    logic                   handshake;

    logic                   ev_on_q;
    logic [NOTE_W-1:0]      ev_note_q;
    logic [VEL_W-1:0]       ev_vel_q;
    logic [PERIOD_W-1:0]    rom_period;

    logic [IDX_W-1:0]       scan_idx;
    logic                   match_vld, free_vld, old_vld;
    logic [IDX_W-1:0]       match_idx, free_idx, old_idx, target_idx;
    logic [AGE_FIELD_W-1:0] old_age;

    assign ev_ready      = ready_q;
    assign voice_restart = restart_q;
    assign handshake     = ev_valid & ready_q;
    assign cur           = voices[scan_idx];

    note_period_rom #(.CLK_HZ(CLK_HZ)) u_rom (
        .clk    (clk),
        .note   (ev_note_q),
        .period (rom_period)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (handshake) state_nxt = LOOKUP;
            LOOKUP:  state_nxt = SCAN;
            SCAN:    if (scan_idx == LAST_IDX) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (panic) state_nxt = IDLE;
    end

    // With no match and no free voice every voice is active, so old_idx is always valid here.
    always_comb begin
        target_idx = old_idx;
        if (match_vld)     target_idx = match_idx;
        else if (free_vld) target_idx = free_idx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ready_q   <= 1'b0;
            restart_q <= '0;
            ev_on_q   <= 1'b0;
            ev_note_q <= '0;
            ev_vel_q  <= '0;
            scan_idx  <= '0;
            match_vld <= 1'b0;
            free_vld  <= 1'b0;
            old_vld   <= 1'b0;
            match_idx <= '0;
            free_idx  <= '0;
            old_idx   <= '0;
            old_age   <= '0;
            for (int i = 0; i < NUM_VOICES; i++) voices[i] <= '0;
        end else begin
            state     <= state_nxt;
            ready_q   <= (state_nxt == IDLE);
            restart_q <= '0;
            if (panic) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    voices[i].active <= 1'b0;
                    voices[i].vel    <= '0;
                    voices[i].age    <= '0;
                end
            end else begin
                case (state)
                    IDLE: if (handshake) begin
                        ev_on_q   <= ev_on && (ev_vel != '0);
                        ev_note_q <= ev_note;
                        ev_vel_q  <= ev_vel;
                    end
                    LOOKUP: begin
                        scan_idx  <= '0;
                        match_vld <= 1'b0;
                        free_vld  <= 1'b0;
                        old_vld   <= 1'b0;
                        old_age   <= '0;
                    end
                    SCAN: begin
                        if (cur.active && cur.note == ev_note_q && !match_vld) begin
                            match_vld <= 1'b1;
                            match_idx <= scan_idx;
                        end
                        if (!cur.active && !free_vld) begin
                            free_vld <= 1'b1;
                            free_idx <= scan_idx;
                        end
                        // Strict compare keeps the lowest index on equal ages.
                        if (cur.active && (!old_vld || cur.age > old_age)) begin
                            old_vld <= 1'b1;
                            old_idx <= scan_idx;
                            old_age <= cur.age;
                        end
                        scan_idx <= scan_idx + 1'b1;
                    end
                    COMMIT: begin
                        if (ev_on_q) begin
                            for (int i = 0; i < NUM_VOICES; i++) begin
                                if (IDX_W'(i) == target_idx) begin
                                    voices[i].active <= 1'b1;
                                    voices[i].note   <= ev_note_q;
                                    voices[i].vel    <= ev_vel_q;
                                    voices[i].period <= rom_period;
                                    voices[i].age    <= '0;
                                    restart_q[i]     <= 1'b1;
                                end else if (voices[i].active) begin
                                    voices[i].age <= (voices[i].age >= AGE_MAX) ? AGE_MAX
                                                                                : voices[i].age + 1'b1;
                                end
                            end
                        end else if (match_vld) begin
                            voices[match_idx].active <= 1'b0;
                            voices[match_idx].vel    <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        voice_period = '0;
        voice_volume = '0;
        voice_active = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_period[PERIOD_W*i +: PERIOD_W] = voices[i].period;
            voice_volume[VEL_W*i +: VEL_W]       = voices[i].vel;
            voice_active[i]                      = voices[i].active;
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed vector table, multi-cycle corner sequences and random events
// compared against an array-based model of the allocation rules.
module tb_voice_allocator;

    localparam int NV     = 4;
    localparam int CLK_HZ = 50_000_000;
    localparam int AGE_MX = 15;

    logic            clk = 1'b0;
    logic            reset, panic, ev_valid, ev_on;
    logic            ev_ready;
    logic [6:0]      ev_note, ev_vel;
    logic [NV*23-1:0] voice_period;
    logic [NV*7-1:0]  voice_volume;
    logic [NV-1:0]    voice_restart, voice_active;

    int n_cmp = 0;
    int n_bad = 0;

    bit m_act    [NV];
    int m_note   [NV];
    int m_vel    [NV];
    int m_period [NV];
    int m_age    [NV];
    int m_restart;

    always #5 clk = ~clk;

    voice_allocator #(.NUM_VOICES(NV), .CLK_HZ(CLK_HZ), .AGE_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .panic         (panic),
        .ev_valid      (ev_valid),
        .ev_ready      (ev_ready),
        .ev_on         (ev_on),
        .ev_note       (ev_note),
        .ev_vel        (ev_vel),
        .voice_period  (voice_period),
        .voice_volume  (voice_volume),
        .voice_restart (voice_restart),
        .voice_active  (voice_active)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int ref_period(input int n);
        real f;
        f = 440.0 * (2.0 ** ((real'(n) - 69.0) / 12.0));
        return $rtoi(real'(CLK_HZ) / f + 0.5);
    endfunction

    function automatic logic [127:0] exp_period();
        logic [127:0] v = '0;
        for (int i = 0; i < NV; i++) v[23*i +: 23] = 23'(m_period[i]);
        return v;
    endfunction

    function automatic logic [127:0] exp_volume();
        logic [127:0] v = '0;
        for (int i = 0; i < NV; i++) v[7*i +: 7] = 7'(m_vel[i]);
        return v;
    endfunction

    function automatic logic [127:0] exp_active();
        logic [127:0] v = '0;
        for (int i = 0; i < NV; i++) v[i] = m_act[i];
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NV; i++) begin
            m_act[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_period[i] = 0; m_age[i] = 0;
        end
        m_restart = 0;
    endfunction

    function automatic void model_panic();
        for (int i = 0; i < NV; i++) begin
            m_act[i] = 0; m_vel[i] = 0; m_age[i] = 0;
        end
    endfunction

    function automatic void model_event(input bit on, input int note, input int vel);
        int match = -1;
        int tgt   = -1;
        m_restart = 0;
        for (int i = NV - 1; i >= 0; i--) if (m_act[i] && m_note[i] == note) match = i;
        if (on && vel != 0) begin
            tgt = match;
            if (tgt < 0) for (int i = NV - 1; i >= 0; i--) if (!m_act[i]) tgt = i;
            if (tgt < 0) begin
                tgt = 0;
                for (int i = 1; i < NV; i++) if (m_age[i] > m_age[tgt]) tgt = i;
            end
            for (int i = 0; i < NV; i++)
                if (i != tgt && m_act[i]) m_age[i] = (m_age[i] < AGE_MX) ? m_age[i] + 1 : AGE_MX;
            m_act[tgt] = 1; m_note[tgt] = note; m_vel[tgt] = vel;
            m_period[tgt] = ref_period(note); m_age[tgt] = 0;
            m_restart = 1 << tgt;
        end else if (match >= 0) begin
            m_act[match] = 0;
            m_vel[match] = 0;
        end
    endfunction

    task automatic wait_ready();
        int k = 0;
        while (!ev_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!ev_ready) chk("ready_timeout", ev_ready, 1);
    endtask

    task automatic send_ev(input bit on, input int note, input int vel);
        wait_ready();
        ev_valid = 1'b1;
        ev_on    = on;
        ev_note  = 7'(note);
        ev_vel   = 7'(vel);
        @(posedge clk);
        @(negedge clk);
        ev_valid = 1'b0;
    endtask

    task automatic do_event(input bit on, input int note, input int vel, input int exp_mask);
        logic [127:0] old_p, old_v, old_a;
        int low = 0;
        old_p = exp_period(); old_v = exp_volume(); old_a = exp_active();
        send_ev(on, note, vel);
        model_event(on, note, vel);
        while (!ev_ready && low < 50) begin
            if (low == NV + 1) begin
                chk("early_period", voice_period, old_p);
                chk("early_volume", voice_volume, old_v);
                chk("early_active", voice_active, old_a);
            end
            @(negedge clk);
            low++;
        end
        chk("ready_low_cycles", low, NV + 2);
        chk("period", voice_period, exp_period());
        chk("volume", voice_volume, exp_volume());
        chk("active", voice_active, exp_active());
        chk("restart", voice_restart, m_restart);
        if (exp_mask >= 0) chk("restart_table", voice_restart, exp_mask);
        @(negedge clk);
        chk("restart_one_cycle", voice_restart, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        chk("rst_ready", ev_ready, 0);
        chk("rst_period", voice_period, 0);
        chk("rst_volume", voice_volume, 0);
        chk("rst_active", voice_active, 0);
        chk("rst_restart", voice_restart, 0);
        reset = 1'b0;
        wait_ready();
    endtask

    typedef struct {
        bit on;
        int note;
        int vel;
        int mask;
    } vec_t;

    vec_t tbl [12];

    initial begin
        reset = 1'b1; panic = 1'b0; ev_valid = 1'b0; ev_on = 1'b0; ev_note = '0; ev_vel = '0;
        model_reset();
        do_reset();

        // Single note: A4 goes to voice 0 with the known period.
        do_event(1, 69, 100, 1);
        chk("a4_period", voice_period[22:0], 113636);
        chk("a4_volume", voice_volume[6:0], 100);

        tbl[0]  = '{1'b1, 60, 80, 1};
        tbl[1]  = '{1'b1, 62, 80, 2};
        tbl[2]  = '{1'b1, 64, 80, 4};
        tbl[3]  = '{1'b1, 65, 80, 8};
        tbl[4]  = '{1'b1, 67, 80, 1};
        tbl[5]  = '{1'b1, 62, 120, 2};
        tbl[6]  = '{1'b0, 64, 0, 0};
        tbl[7]  = '{1'b0, 70, 0, 0};
        tbl[8]  = '{1'b1, 65, 0, 0};
        tbl[9]  = '{1'b1, 50, 90, 4};
        tbl[10] = '{1'b1, 51, 90, 8};
        tbl[11] = '{1'b1, 52, 90, 1};
        do_reset();
        for (int t = 0; t < 12; t++) do_event(tbl[t].on, tbl[t].note, tbl[t].vel, tbl[t].mask);

        // Age saturation: voice 0 must stay oldest after 17 increments.
        do_reset();
        do_event(1, 10, 50, 1);
        for (int k = 0; k < 15; k++) do_event(1, 11, 50 + k, 2);
        do_event(1, 12, 50, 4);
        do_event(1, 13, 50, 8);
        do_event(1, 14, 50, 1);

        // Panic while scanning.
        do_reset();
        do_event(1, 69, 100, 1);
        send_ev(1, 60, 90);
        @(negedge clk);
        @(negedge clk);
        panic = 1'b1;
        @(negedge clk);
        panic = 1'b0;
        model_panic();
        chk("panic_volume", voice_volume, 0);
        chk("panic_active", voice_active, 0);
        chk("panic_ready", ev_ready, 1);
        chk("panic_period", voice_period, exp_period());
        for (int k = 0; k < NV + 3; k++) begin
            @(negedge clk);
            chk("panic_no_restart", voice_restart, 0);
        end
        chk("panic_active_after", voice_active, 0);

        // Panic concurrent with a handshake drops the event.
        ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd40; ev_vel = 7'd60; panic = 1'b1;
        @(negedge clk);
        ev_valid = 1'b0; panic = 1'b0;
        chk("panic_hs_ready", ev_ready, 1);
        repeat (NV + 3) @(negedge clk);
        chk("panic_hs_active", voice_active, 0);
        do_event(1, 41, 33, 1);

        // Reset while in COMMIT.
        send_ev(1, 60, 90);
        repeat (NV + 1) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        chk("rst_commit_period", voice_period, 0);
        chk("rst_commit_volume", voice_volume, 0);
        chk("rst_commit_active", voice_active, 0);
        chk("rst_commit_restart", voice_restart, 0);
        chk("rst_commit_ready", ev_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_commit_restart2", voice_restart, 0);
        wait_ready();

        // Random traffic on a narrow note range so matches and steals are frequent.
        for (int k = 0; k < 80; k++) begin
            bit r_on;
            int r_note, r_vel;
            r_on   = ($urandom_range(0, 2) != 0);
            r_note = 60 + $urandom_range(0, 7);
            r_vel  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 127);
            do_event(r_on, r_note, r_vel, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
